// File: rtl/vga_pmod_out_stage.sv
// vga_pmod_out_stage: registers sync/blanking and maps 6-bit depth to dithered 2-bit RGB for the TinyVGA PMOD.
module vga_pmod_out_stage #(
  parameter int SYNC_DLY = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       display_on_in,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [5:0] depth,
  input  logic [1:0] mode,
  input  logic       temporal_en,
  output logic [7:0] uo_out,
  output logic [9:0] frame_cnt
);
  localparam logic [3:0] BAYER [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  function automatic logic [1:0] quant(input logic [5:0] v, input logic [3:0] t);
    logic [7:0] s;
    logic [2:0] sum;
    s = {v, v[5:4]};
    sum = {1'b0, s[7:6]} + {2'b0, s[5:2] > t};
    return sum[2] ? 2'd3 : sum[1:0];
  endfunction

  logic       unused_xy;
  logic [2:0] sd;
  logic       vs_q, temp_r, fall;
  logic [1:0] mode_r;
  logic [5:0] d1, heat_v;
  logic [1:0] x1, y1, col, qd, qi, qh, rr, gg, bb;
  logic [3:0] thr;
  logic       hs1, vs1, de1;

  assign unused_xy = ^{x[9:2], y[9:2]};

  // sync/display_on pre-delay to match the upstream pixel pipeline depth
  generate
    if (SYNC_DLY == 0) begin : g_nodly
      assign sd = {hsync_in, vsync_in, display_on_in};
    end else begin : g_dly
      logic [2:0] sr [SYNC_DLY];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_DLY; i++) sr[i] <= 3'b110;
        end else begin
          sr[0] <= {hsync_in, vsync_in, display_on_in};
          for (int i = 1; i < SYNC_DLY; i++) sr[i] <= sr[i-1];
        end
      end
      assign sd = sr[SYNC_DLY-1];
    end
  endgenerate

  assign fall = vs_q & ~vsync_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q      <= 1'b1;
      frame_cnt <= '0;
      mode_r    <= '0;
      temp_r    <= 1'b0;
    end else begin
      vs_q <= vsync_in;
      if (fall) begin
        frame_cnt <= frame_cnt + 10'd1;
        mode_r    <= mode;
        temp_r    <= temporal_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d1  <= '0;
      x1  <= '0;
      y1  <= '0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      de1 <= 1'b0;
    end else begin
      d1  <= depth;
      x1  <= x[1:0];
      y1  <= y[1:0];
      {hs1, vs1, de1} <= sd;
    end
  end

  always_comb begin
    col    = x1 + (temp_r ? frame_cnt[1:0] : 2'd0);
    thr    = BAYER[{y1, col}];
    heat_v = d1[5] ? 6'd63 : {d1[4:0], 1'b0};
    qd     = quant(d1, thr);
    qi     = quant(~d1, thr);
    qh     = quant(heat_v, thr);
    rr     = mode_r == 2'd1 ? d1[5:4] : mode_r == 2'd2 ? qh : mode_r == 2'd3 ? qi : qd;
    gg     = mode_r == 2'd1 ? d1[3:2] : mode_r == 2'd3 ? qi : qd;
    bb     = mode_r == 2'd1 ? d1[1:0] : mode_r == 2'd2 ? 2'd0 : mode_r == 2'd3 ? qi : qd;
    rr     = de1 ? rr : 2'd0;
    gg     = de1 ? gg : 2'd0;
    bb     = de1 ? bb : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) uo_out <= 8'b1000_1000;
    else uo_out <= {hs1, bb[0], gg[0], rr[0], vs1, bb[1], gg[1], rr[1]};
  end
endmodule

// File: tb/tb_vga_pmod_out_stage.sv
// tb_vga_pmod_out_stage: directed checks of reset, dithering, palettes, frame counting and sync alignment.
module tb_vga_pmod_out_stage;
  logic       clk, rst_n, hsync_in, vsync_in, display_on_in, temporal_en;
  logic [9:0] x, y;
  logic [5:0] depth;
  logic [1:0] mode;
  logic [7:0] uo_out;
  logic [9:0] frame_cnt;
  int total = 0, bad = 0;
  logic [7:0] exp_uo;

  vga_pmod_out_stage #(.SYNC_DLY(3)) dut (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .display_on_in(display_on_in), .x(x), .y(y), .depth(depth), .mode(mode),
    .temporal_en(temporal_en), .uo_out(uo_out), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic px(input logic [5:0] d, input logic [1:0] xx, input logic [1:0] yy);
    depth = d;
    x = {8'd0, xx};
    y = {8'd0, yy};
    tick(2);
  endtask

  task automatic pulse();
    vsync_in = 1'b0;
    tick();
    vsync_in = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
      display_on_in = 1'($urandom_range(0, 1));
      depth = 6'($urandom);
      x = 10'($urandom);
      y = 10'($urandom);
      mode = 2'($urandom);
      temporal_en = 1'($urandom_range(0, 1));
      tick();
      total++;
      if (uo_out !== 8'h88 || frame_cnt !== 10'd0) begin
        bad++;
        $display("FAIL reset_hold: uo_out=%h frame_cnt=%0d want 88/0", uo_out, frame_cnt);
      end
    end
    {hsync_in, vsync_in, display_on_in, temporal_en} = 4'b1100;
    depth = 0; x = 0; y = 0; mode = 0;
    rst_n = 1'b1;
    tick();
    total++;
    if (uo_out !== 8'h88 || frame_cnt !== 10'd0) begin
      bad++;
      $display("FAIL reset_release: uo_out=%h frame_cnt=%0d want 88/0", uo_out, frame_cnt);
    end
  endtask

  task automatic test_dither_extremes();
    display_on_in = 1'b1;
    tick(6);
    for (int k = 0; k < 2; k++)
      for (int yy = 0; yy < 4; yy++)
        for (int xx = 0; xx < 4; xx++) begin
          px(k == 0 ? 6'd0 : 6'd63, 2'(xx), 2'(yy));
          exp_uo = k == 0 ? 8'h88 : 8'hFF;
          total++;
          if (uo_out !== exp_uo) begin
            bad++;
            $display("FAIL extreme x=%0d y=%0d: uo_out=%h want %h", xx, yy, uo_out, exp_uo);
          end
        end
  endtask

  task automatic test_dither_pattern();
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++) begin
        px(6'd33, 2'(xx), 2'(yy));
        exp_uo = (xx == 0 && yy == 0) ? 8'hFF : 8'h8F;
        total++;
        if (uo_out !== exp_uo) begin
          bad++;
          $display("FAIL pattern x=%0d y=%0d: uo_out=%h want %h", xx, yy, uo_out, exp_uo);
        end
      end
    temporal_en = 1'b1;
    pulse();
    temporal_en = 1'b0;
    total++;
    if (frame_cnt !== 10'd1) begin
      bad++;
      $display("FAIL temporal_fc: frame_cnt=%0d want 1", frame_cnt);
    end
    tick(6);
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 4; xx++) begin
        px(6'd33, 2'(xx), 2'(yy));
        exp_uo = (xx == 3 && yy == 0) ? 8'hFF : 8'h8F;
        total++;
        if (uo_out !== exp_uo) begin
          bad++;
          $display("FAIL temporal x=%0d y=%0d: uo_out=%h want %h", xx, yy, uo_out, exp_uo);
        end
      end
  endtask

  task automatic test_frame_counter();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mode = 2'd0;
    tick();
    pulse();
    mode = 2'd1;
    tick(6);
    px(6'h2D, 2'd0, 2'd0);
    total++;
    if (uo_out !== 8'hFF) begin
      bad++;
      $display("FAIL mode_midframe: uo_out=%h want ff", uo_out);
    end
    pulse();
    tick(6);
    px(6'h2D, 2'd0, 2'd0);
    total++;
    if (uo_out !== 8'hEB) begin
      bad++;
      $display("FAIL direct_00: uo_out=%h want eb", uo_out);
    end
    px(6'h2D, 2'd1, 2'd1);
    total++;
    if (uo_out !== 8'hEB) begin
      bad++;
      $display("FAIL direct_11: uo_out=%h want eb", uo_out);
    end
    total++;
    if (frame_cnt !== 10'd2) begin
      bad++;
      $display("FAIL fc_two: frame_cnt=%0d want 2", frame_cnt);
    end
    for (int i = 0; i < 1021; i++) pulse();
    total++;
    if (frame_cnt !== 10'd1023) begin
      bad++;
      $display("FAIL fc_1023: frame_cnt=%0d want 1023", frame_cnt);
    end
    pulse();
    total++;
    if (frame_cnt !== 10'd0) begin
      bad++;
      $display("FAIL fc_wrap: frame_cnt=%0d want 0", frame_cnt);
    end
    pulse();
    total++;
    if (frame_cnt !== 10'd1) begin
      bad++;
      $display("FAIL fc_1025: frame_cnt=%0d want 1", frame_cnt);
    end
    tick(6);
  endtask

  task automatic test_palettes();
    mode = 2'd2;
    pulse();
    tick(6);
    px(6'd20, 2'd0, 2'd0);
    total++;
    if (uo_out !== 8'h9B) begin
      bad++;
      $display("FAIL heat_20_00: uo_out=%h want 9b", uo_out);
    end
    px(6'd20, 2'd1, 2'd0);
    total++;
    if (uo_out !== 8'hA9) begin
      bad++;
      $display("FAIL heat_20_10: uo_out=%h want a9", uo_out);
    end
    px(6'd40, 2'd0, 2'd0);
    total++;
    if (uo_out !== 8'hBB) begin
      bad++;
      $display("FAIL heat_40_00: uo_out=%h want bb", uo_out);
    end
    px(6'd40, 2'd1, 2'd0);
    total++;
    if (uo_out !== 8'h9B) begin
      bad++;
      $display("FAIL heat_40_10: uo_out=%h want 9b", uo_out);
    end
    mode = 2'd3;
    pulse();
    tick(6);
    px(6'd30, 2'd0, 2'd0);
    total++;
    if (uo_out !== 8'hFF) begin
      bad++;
      $display("FAIL inv_30_00: uo_out=%h want ff", uo_out);
    end
    px(6'd30, 2'd1, 2'd0);
    total++;
    if (uo_out !== 8'h8F) begin
      bad++;
      $display("FAIL inv_30_10: uo_out=%h want 8f", uo_out);
    end
    px(6'd63, 2'd2, 2'd2);
    total++;
    if (uo_out !== 8'h88) begin
      bad++;
      $display("FAIL inv_63: uo_out=%h want 88", uo_out);
    end
  endtask

  task automatic test_alignment();
    mode = 2'd0;
    pulse();
    tick(6);
    depth = 6'd63;
    x = 0;
    y = 0;
    tick(3);
    hsync_in = 1'b0;
    display_on_in = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      hsync_in = 1'b1;
      display_on_in = 1'b1;
      exp_uo = i == 5 ? 8'h08 : 8'hFF;
      total++;
      if (uo_out !== exp_uo) begin
        bad++;
        $display("FAIL align_cycle%0d: uo_out=%h want %h", i, uo_out, exp_uo);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(6);
    total++;
    if (uo_out !== 8'hFF) begin
      bad++;
      $display("FAIL pre_reset: uo_out=%h want ff", uo_out);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if (uo_out !== 8'h88 || frame_cnt !== 10'd0) begin
      bad++;
      $display("FAIL mid_reset: uo_out=%h frame_cnt=%0d want 88/0", uo_out, frame_cnt);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (uo_out !== 8'h88) begin
      bad++;
      $display("FAIL post_reset_first: uo_out=%h want 88", uo_out);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (frame_cnt !== 10'd0) begin
        bad++;
        $display("FAIL spurious_count: frame_cnt=%0d want 0", frame_cnt);
      end
    end
    pulse();
    total++;
    if (frame_cnt !== 10'd1) begin
      bad++;
      $display("FAIL real_edge: frame_cnt=%0d want 1", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_dither_extremes();
    test_dither_pattern();
    test_frame_counter();
    test_palettes();
    test_alignment();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_pmod_out_stage.md
# vga_pmod_out_stage

Output stage between the pixel generator (hvsync timing plus 6-bit layer/depth value) and the TinyVGA PMOD pins. It registers and delay-aligns sync and blanking, and converts the 6-bit depth to 2-bit-per-channel RGB through a selectable palette with 4x4 ordered (Bayer) dithering, optionally temporal. It also provides a clk-domain frame counter that upstream animation logic uses instead of clocking on vsync.

## Interface
- SYNC_DLY, 0: extra cycles of delay on hsync/vsync/display_on only, to cover upstream pixel pipeline depth; legal range 0..7.
- clk  in  1  pixel clock.
- rst_n  in  1  reset, synchronous, active-low.
- hsync_in  in  1  horizontal sync from timing generator, active-low.
- vsync_in  in  1  vertical sync from timing generator, active-low.
- display_on_in  in  1  visible-area flag.
- x  in  10  pixel column; only x[1:0] used.
- y  in  10  pixel row; only y[1:0] used.
- depth  in  6  pixel value from the generator; 0..63.
- mode  in  2  palette select: 0 grey, 1 direct, 2 heat, 3 inverted grey.
- temporal_en  in  1  enables frame-rotated dither.
- uo_out  out  8  PMOD pins {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}.
- frame_cnt  out  10  frames elapsed; wraps 1023->0.

## Operation
- Sync path: hsync_in, vsync_in and display_on_in pass through a SYNC_DLY-deep shift register, then through the same 2 register stages as colour.
- Frame counter: vsync_in is registered once (vs_q). A falling edge (vs_q=1, vsync_in=0) increments frame_cnt by exactly 1 per sync pulse. Counting is in the clk domain only.
- Mode latch: mode and temporal_en are captured into mode_r/temp_r only on the same falling-edge cycle. Changes mid-frame take effect at the next frame.
- Bayer threshold b (4 bits), indexed by row r=y[1:0] and column c:
  - rows: r0 = 0 8 2 10; r1 = 12 4 14 6; r2 = 3 11 1 9; r3 = 15 7 13 5.
  - c = x[1:0] when temp_r=0.
  - c = (x[1:0] + frame_cnt[1:0]) mod 4 when temp_r=1.
- Quantiser q(v) for a 6-bit v:
  - s = {v, v[5:4]} (8-bit).
  - q = s[7:6] + (s[5:2] > b), saturated at 3.
  - Consequences: q(0)=0 and q(63)=3 at every position.
- Palettes (all channels dithered with the same b):
  - mode 0 (grey): R=G=B=q(depth).
  - mode 1 (direct): {R,G,B}=depth, no dither.
  - mode 2 (heat): R=q(min(2·depth,63)), G=q(depth), B=0.
  - mode 3 (inverted grey): R=G=B=q(63−depth).
- Blanking: R, G and B are forced to 0 when the aligned display_on is 0. Sync is never blanked.
- Reset (rst_n=0 at a clk edge):
  - all pipeline colour bits reset to 0; sync bits reset to 1 (inactive);
  - frame_cnt=0; vs_q=1; mode_r=0; temp_r=0.
  - Therefore uo_out=8'b1000_1000 during reset and on the first cycle after it.
  - Reset mid-frame discards in-flight pixels and no frame edge is counted on release.

## Timing
- Pipeline stages:
  - Stage 1 registers depth, x[1:0], y[1:0] and the delayed sync/display_on.
  - Stage 2 registers quantised RGB plus sync into uo_out.
- Latency:
  - colour: depth -> uo_out is 2 cycles.
  - sync/display_on: 2+SYNC_DLY cycles.
- frame_cnt and mode_r update 1 cycle after the vsync_in falling edge is sampled. The first pixel of the next frame uses the new values.
- No backpressure; the block accepts one pixel per cycle, every cycle.
- If vsync_in glitches low-high-low, each falling edge counts.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs -> uo_out=0x88 and frame_cnt=0 throughout, and on the first post-reset cycle.
- Dither extremes: mode 0, display_on=1, depth=0 then 63 across a 4x4 tile -> RGB=0 everywhere, then RGB=3 everywhere (uo_out=0xFF with syncs inactive).
- Dither pattern: mode 0, depth=33 (s=134, level 2, frac 1) over 4x4 tile, temporal off -> q=3 only at x=0,y=0 and q=2 at the other 15 positions. With temporal on and frame_cnt[1:0]=1 -> q=3 at x=3,y=0.
- Frame counter and mode latch: 1025 vsync pulses, with mode switched 0->1 mid-frame:
  - frame_cnt ends at 1, after wrapping through 1023->0;
  - mode 1 output appears only after the next falling edge;
  - direct depth=0x2D gives RGB 10/11/01.
- Blanking and alignment: SYNC_DLY=3, single-cycle hsync_in low pulse and display_on toggle -> hsync on uo_out[7] is low exactly 5 cycles later. Colour is 0 whenever the aligned display_on=0.
- Reset mid-frame: assert rst_n=0 during the active area with depth=63 -> next cycle uo_out=0x88 and frame_cnt=0. After release, no spurious increment occurs until a real vsync falling edge.
